la_ram_loader: RTL and testbench

Logic-analyzer-driven program loader inside the user project wrapper. Management firmware drives address, data and a write toggle over LA probes. This block synchronises those probes, writes each word into the simple CPU's instruction/data RAM, and acknowledges each write. It holds the CPU in reset while a load is in progress and releases it when firmware ends the load session.

---
 rtl/la_ram_loader_pkg.sv | 15 +
 rtl/la_ram_loader_if.sv | 21 ++
 rtl/la_ram_loader_sync2.sv | 22 ++
 rtl/la_ram_loader.sv | 100 ++++++++++
 tb/tb_la_ram_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/la_ram_loader_pkg.sv
// Shared types and default widths for the LA-driven program loader.
package la_loader_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/la_ram_loader_if.sv
// Firmware-facing LA probe bundle: load request, write toggle, addr/data in, ack toggle out.
interface la_ram_loader_if import la_loader_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              la_load_en;
  logic              la_wr_toggle;
  logic [ADDR_W-1:0] la_addr;
  logic [DATA_W-1:0] la_wdata;
  logic              la_ack_toggle;

  modport master (
    output la_load_en, la_wr_toggle, la_addr, la_wdata,
    input  la_ack_toggle
  );

  modport slave (
    input  la_load_en, la_wr_toggle, la_addr, la_wdata,
    output la_ack_toggle
  );
endinterface

// File: rtl/la_ram_loader_sync2.sv
// Two-flop synchroniser for a single asynchronous level; 2-cycle latency, resets to 0.
module la_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/la_ram_loader.sv
// Loads CPU RAM from LA probes: toggle-handshaked word writes, CPU held in reset during a session.
// Toggle-to-write latency 3 edges; firmware paces itself by waiting for the ack toggle.
module la_ram_loader import la_loader_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  la_ram_loader_if.slave    la,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              cpu_rst_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              err_o
);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              load_s, tog_s, tog_prev_q, tog_edge;
  logic              capture, session_start;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  la_sync2 u_sync_load (.clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(la.la_load_en),   .q_o(load_s));
  la_sync2 u_sync_tog  (.clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(la.la_wr_toggle), .q_o(tog_s));

  assign tog_edge = tog_s ^ tog_prev_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= HOLD;
      tog_prev_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tog_prev_q <= tog_s;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // A pending toggle edge in LOAD wins over the session ending.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    if (load_s) state_d = LOAD;
      LOAD:    if (tog_edge) state_d = WRITE;
               else if (!load_s) state_d = DRAIN;
      WRITE:   state_d = load_s ? LOAD : DRAIN;
      DRAIN:   state_d = RUN;
      RUN:     if (load_s) state_d = LOAD;
      default: state_d = HOLD;
    endcase
  end

  assign capture       = (state_q == LOAD) && tog_edge;
  assign session_start = ((state_q == HOLD) || (state_q == RUN)) && (state_d == LOAD);

  // An unexpected edge on the session-start cycle still flags, so set beats clear.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (session_start) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (capture) begin
      addr_d  = la.la_addr;
      wdata_d = la.la_wdata;
      ack_d   = tog_s;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    if (tog_edge && (state_q != LOAD)) err_d = 1'b1;
  end

  always_comb begin
    ram_we_o  = (state_q == WRITE);
    cpu_rst_o = (state_q != RUN);
  end

  assign ram_addr_o       = addr_q;
  assign ram_wdata_o      = wdata_q;
  assign la.la_ack_toggle = ack_q;
  assign word_count_o     = cnt_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_la_ram_loader.sv
// Directed + randomized bench for la_ram_loader against a shadow RAM and word-count model.
module tb_la_ram_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_rst;
  logic [8:0] word_cnt;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wide_pulses = 0;
  int exp_cnt = 0;
  int c, n0;
  logic we_prev = 1'b0;
  logic tog_first;

  logic [7:0] pa[$];
  logic [7:0] pd[$];
  int         pc[$];
  logic [7:0] model_mem [256];
  logic [7:0] dut_mem   [256];

  la_ram_loader_if #(.ADDR_W(8), .DATA_W(8)) la_if ();

  la_ram_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la          (la_if),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .cpu_rst_o   (cpu_rst),
    .word_count_o(word_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write strobe seen by the CPU-side RAM.
  always @(negedge clk) begin
    if (ram_we) begin
      pa.push_back(ram_addr);
      pd.push_back(ram_wdata);
      pc.push_back(cyc);
      dut_mem[ram_addr] <= ram_wdata;
      if (we_prev) wide_pulses <= wide_pulses + 1;
    end
    we_prev <= ram_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int base, c0, t;
    base = pa.size();
    la_if.la_addr  = a;
    la_if.la_wdata = d;
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    c0 = cyc;
    t  = 0;
    while (pa.size() == base && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_cnt < 256) exp_cnt++;
    model_mem[a] = d;
    chk("wr_timeout", 32'(pa.size() > base), 32'd1);
    if (pa.size() > base) begin
      chk("wr_addr", 32'(pa[base]), 32'(a));
      chk("wr_data", 32'(pd[base]), 32'(d));
      chk("wr_latency", 32'(pc[base] - c0), 32'd3);
    end
    chk("wr_ack", 32'(la_if.la_ack_toggle), 32'(la_if.la_wr_toggle));
    chk("wr_cnt", 32'(word_cnt), 32'(exp_cnt));
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      dut_mem[i]   = 8'h00;
    end
    la_if.la_load_en   = 1'b0;
    la_if.la_wr_toggle = 1'b0;
    la_if.la_addr      = 8'h00;
    la_if.la_wdata     = 8'h00;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ack", 32'(la_if.la_ack_toggle), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step(3);
    rst = 1'b0;

    // Idle in HOLD
    step(20);
    chk("idle_no_we", 32'(pa.size()), 32'd0);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("idle_err", 32'(err), 32'd0);

    // First session: four sequential words
    la_if.la_load_en = 1'b1;
    step(3);
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) do_write(8'(i), 8'(8'hA0 + i));
    chk("s1_cnt", 32'(word_cnt), 32'd4);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd1);

    // End session: DRAIN then RUN three edges after the drop
    la_if.la_load_en = 1'b0;
    c = cyc;
    step(3);
    chk("drain_cpu_rst", 32'(cpu_rst), 32'd1);
    step(1);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_lat", 32'(cyc - c), 32'd4);

    // Toggle while running is a protocol error
    n0 = pa.size();
    tog_first = la_if.la_wr_toggle;
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    step(6);
    chk("run_tog_err", 32'(err), 32'd1);
    chk("run_tog_no_we", 32'(pa.size()), 32'(n0));
    chk("run_tog_ack", 32'(la_if.la_ack_toggle), 32'(tog_first));

    // Re-enter LOAD from RUN
    la_if.la_load_en = 1'b1;
    step(2);
    chk("reload_still_run", 32'(cpu_rst), 32'd0);
    step(1);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_err_clr", 32'(err), 32'd0);
    chk("reload_cnt_clr", 32'(word_cnt), 32'd0);

    // Toggle and drop load_en together: write, DRAIN, RUN
    n0 = pa.size();
    la_if.la_addr  = 8'h10;
    la_if.la_wdata = 8'h5A;
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    la_if.la_load_en   = 1'b0;
    c = cyc;
    step(3);
    chk("both_we", 32'(ram_we), 32'd1);
    step(1);
    chk("both_drain", 32'(cpu_rst), 32'd1);
    step(1);
    chk("both_run", 32'(cpu_rst), 32'd0);
    chk("both_one_write", 32'(pa.size()), 32'(n0 + 1));
    chk("both_addr", 32'(pa[n0]), 32'h10);
    chk("both_data", 32'(pd[n0]), 32'h5A);
    chk("both_lat", 32'(pc[n0] - c), 32'd3);
    chk("both_cnt", 32'(word_cnt), 32'd1);
    chk("both_ack", 32'(la_if.la_ack_toggle), 32'(la_if.la_wr_toggle));
    model_mem[8'h10] = 8'h5A;

    // Double toggle one cycle apart: second edge lands in WRITE
    la_if.la_load_en = 1'b1;
    step(3);
    chk("dbl_err_clr", 32'(err), 32'd0);
    n0 = pa.size();
    la_if.la_addr  = 8'h22;
    la_if.la_wdata = 8'hC3;
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    tog_first = la_if.la_wr_toggle;
    c = cyc;
    step(1);
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    step(6);
    chk("dbl_one_write", 32'(pa.size()), 32'(n0 + 1));
    chk("dbl_addr", 32'(pa[n0]), 32'h22);
    chk("dbl_data", 32'(pd[n0]), 32'hC3);
    chk("dbl_lat", 32'(pc[n0] - c), 32'd3);
    chk("dbl_err", 32'(err), 32'd1);
    chk("dbl_ack", 32'(la_if.la_ack_toggle), 32'(tog_first));
    model_mem[8'h22] = 8'hC3;
    exp_cnt = 1;

    // Random writes with random gaps
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 3));
      do_write(8'($urandom), 8'($urandom));
    end

    // New session, run past saturation with wrapping addresses
    la_if.la_load_en = 1'b0;
    step(6);
    chk("sat_in_run", 32'(cpu_rst), 32'd0);
    la_if.la_load_en = 1'b1;
    step(3);
    exp_cnt = 0;
    chk("sat_cnt_clr", 32'(word_cnt), 32'd0);
    chk("sat_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 258; i++) do_write(8'(i), 8'($urandom));
    chk("sat_cnt", 32'(word_cnt), 32'd256);
    chk("sat_err", 32'(err), 32'd0);
    chk("single_cycle_we", 32'(wide_pulses), 32'd0);
    for (int i = 0; i < 256; i++) chk("ram_image", 32'(dut_mem[i]), 32'(model_mem[i]));

    // Reset during WRITE
    la_if.la_addr  = 8'h7E;
    la_if.la_wdata = 8'hE7;
    la_if.la_wr_toggle = ~la_if.la_wr_toggle;
    step(3);
    chk("mid_we_high", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_we_drop", 32'(ram_we), 32'd0);
    chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_addr", 32'(ram_addr), 32'd0);
    chk("mid_wdata", 32'(ram_wdata), 32'd0);
    chk("mid_ack", 32'(la_if.la_ack_toggle), 32'd0);
    chk("mid_cnt", 32'(word_cnt), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    chk("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
